arcade_input_mapper: RTL and testbench

//  Parametrised player-input front end for arcade cores. It sits between hps_io and the game core.
//  - Decodes ps2_key events against a run-time loadable keymap and merges them with the joysticks.
//  - Applies screen-orientation remapping of the directions.
//  - Generates timed coin pulses per player, with optional start-triggered auto-coin sequencing.
//  - Replaces per-core hard-coded keyboard case tables and ad-hoc coin ORing.

---
 rtl/arcade_input_mapper.sv | 207 ++++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// Player-input front end: keymap-driven keyboard decode merged with joysticks,
// orientation remap of directions, and per-player timed coin pulses with optional auto-coin.
module arcade_input_mapper #(
   parameter int PLAYERS     = 2,
   parameter int BUTTONS     = 6,
   parameter int COIN_CYCLES = 110000,
   parameter int AUTO_COIN   = 1
) (
   input  logic                         clk_sys,
   input  logic                         reset,
   input  logic [10:0]                  ps2_key,
   input  logic [16*PLAYERS-1:0]        joy_in,
   input  logic                         joy_share,
   input  logic [1:0]                   rot,
   input  logic                         map_wr,
   input  logic [7:0]                   map_idx,
   input  logic [8:0]                   map_code,
   output logic [4*PLAYERS-1:0]         dir_out,
   output logic [BUTTONS*PLAYERS-1:0]   btn_out,
   output logic [PLAYERS-1:0]           start_out,
   output logic [PLAYERS-1:0]           coin_out
);
   localparam int FIELDS  = BUTTONS + 6;
   localparam int ENTRIES = PLAYERS * FIELDS;
   localparam int CW      = $clog2(COIN_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(COIN_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_COIN, S_GAP, S_PASS} coin_state_t;

   // Start and coin sit after the buttons, so they are matched before the button slots.
   function automatic logic [8:0] default_code(input int p, input int f);
      logic [8:0] c;
      c = 9'h000;
      if (p == 0) begin
         if (f == BUTTONS + 4)      c = 9'h016;
         else if (f == BUTTONS + 5) c = 9'h02E;
         else begin
            case (f)
               0: c = 9'h174;
               1: c = 9'h16B;
               2: c = 9'h172;
               3: c = 9'h175;
               4: c = 9'h029;
               5: c = 9'h014;
               6: c = 9'h011;
               default: c = 9'h000;
            endcase
         end
      end else if (p == 1) begin
         if (f == BUTTONS + 4)      c = 9'h01E;
         else if (f == BUTTONS + 5) c = 9'h036;
         else begin
            case (f)
               0: c = 9'h034;
               1: c = 9'h023;
               2: c = 9'h02B;
               3: c = 9'h02D;
               4: c = 9'h01C;
               5: c = 9'h01B;
               default: c = 9'h000;
            endcase
         end
      end
      return c;
   endfunction

   logic               toggle_q;
   logic               key_event;
   logic [ENTRIES-1:0] key_state;

   assign key_event = ps2_key[10] ^ toggle_q;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) toggle_q <= 1'b0;
      else       toggle_q <= ps2_key[10];
   end

   // Keymap is matched against every entry in parallel, so each entry is its own register.
   for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic [8:0] code_q;
      logic       hit_q;
      always_ff @(posedge clk_sys or posedge reset) begin
         if (reset) begin
            code_q <= default_code(gi / FIELDS, gi % FIELDS);
            hit_q  <= 1'b0;
         end else if (map_wr && map_idx == 8'(gi)) begin
            code_q <= map_code;
            hit_q  <= 1'b0;
         end else if (key_event && code_q != 9'h000 && code_q == ps2_key[8:0]) begin
            hit_q  <= ps2_key[9];
         end
      end
      assign key_state[gi] = hit_q;
   end

   logic [FIELDS-1:0] raw_own [PLAYERS];
   logic [FIELDS-1:0] raw_any;

   always_comb begin
      raw_any = '0;
      for (int p = 0; p < PLAYERS; p++) begin
         raw_own[p] = key_state[p*FIELDS +: FIELDS] | joy_in[p*16 +: FIELDS];
         raw_any    = raw_any | raw_own[p];
      end
   end

   for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_player
      logic [FIELDS-1:0] raw;
      logic              raw_coin, raw_start;
      logic [3:0]        game_dir;
      logic              unused_joy;
      coin_state_t       state_q, state_d;
      logic [CW-1:0]     cnt_q, cnt_d;
      logic              src_q, src_d;
      logic              coin_prev_q, start_prev_q;
      logic              start_d;
      logic [3:0]        dir_q;
      logic [BUTTONS-1:0] btn_q;
      logic              start_q, coin_q;

      assign raw        = joy_share ? raw_any : raw_own[gi];
      assign raw_start  = raw[BUTTONS+4];
      assign raw_coin   = raw[BUTTONS+5];
      assign unused_joy = ^joy_in[gi*16+FIELDS +: 16-FIELDS];

      // Vectors are {U,D,L,R}; each game direction picks one physical direction.
      always_comb begin
         case (rot)
            2'd1:    game_dir = {raw[1], raw[0], raw[2], raw[3]};
            2'd2:    game_dir = {raw[0], raw[1], raw[3], raw[2]};
            2'd3:    game_dir = {raw[2], raw[3], raw[0], raw[1]};
            default: game_dir = raw[3:0];
         endcase
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         src_d   = src_q;
         case (state_q)
            S_IDLE: begin
               if (raw_coin && !coin_prev_q) begin
                  state_d = S_COIN;
                  cnt_d   = '0;
                  src_d   = 1'b0;
               end else if (AUTO_COIN != 0 && raw_start && !start_prev_q) begin
                  state_d = S_COIN;
                  cnt_d   = '0;
                  src_d   = 1'b1;
               end
            end
            S_COIN: begin
               if (cnt_q == CNT_LAST) begin
                  state_d = S_GAP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_GAP: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = (src_q && raw_start) ? S_PASS : S_IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            S_PASS: begin
               if (!raw_start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
         start_d = 1'b0;
         if (state_d == S_PASS)                       start_d = raw_start;
         else if (state_d == S_IDLE && AUTO_COIN == 0) start_d = raw_start;
      end

      always_ff @(posedge clk_sys or posedge reset) begin
         if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            src_q        <= 1'b0;
            coin_prev_q  <= 1'b0;
            start_prev_q <= 1'b0;
            dir_q        <= '0;
            btn_q        <= '0;
            start_q      <= 1'b0;
            coin_q       <= 1'b0;
         end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            src_q        <= src_d;
            coin_prev_q  <= raw_coin;
            start_prev_q <= raw_start;
            dir_q        <= game_dir;
            btn_q        <= raw[4 +: BUTTONS];
            start_q      <= start_d;
            coin_q       <= (state_d == S_COIN);
         end
      end

      assign dir_out[gi*4 +: 4]             = dir_q;
      assign btn_out[gi*BUTTONS +: BUTTONS] = btn_q;
      assign start_out[gi]                  = start_q;
      assign coin_out[gi]                   = coin_q;
   end
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a timestamp-based behavioural model.
module tb_arcade_input_mapper;
   localparam int P  = 2;
   localparam int B  = 6;
   localparam int C  = 4;
   localparam int AC = 1;
   localparam int F  = B + 6;
   localparam int NE = P * F;

   logic            clk_sys = 1'b0;
   logic            reset   = 1'b1;
   logic [10:0]     ps2_key;
   logic [16*P-1:0] joy_in;
   logic            joy_share;
   logic [1:0]      rot;
   logic            map_wr;
   logic [7:0]      map_idx;
   logic [8:0]      map_code;
   logic [4*P-1:0]  dir_out;
   logic [B*P-1:0]  btn_out;
   logic [P-1:0]    start_out;
   logic [P-1:0]    coin_out;

   arcade_input_mapper #(.PLAYERS(P), .BUTTONS(B), .COIN_CYCLES(C), .AUTO_COIN(AC)) dut (
      .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joy_in(joy_in),
      .joy_share(joy_share), .rot(rot), .map_wr(map_wr), .map_idx(map_idx),
      .map_code(map_code), .dir_out(dir_out), .btn_out(btn_out),
      .start_out(start_out), .coin_out(coin_out)
   );

   always #5 clk_sys = ~clk_sys;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: keymap, key states, and per-player coin sequence start times.
   logic [8:0]     m_map [NE];
   bit             m_key [NE];
   bit             m_tog;
   bit             m_pc [P], m_ps [P], m_busy [P], m_src [P], m_pass [P];
   int             m_t0 [P];
   int             m_n;
   logic [4*P-1:0] e_dir;
   logic [B*P-1:0] e_btn;
   logic [P-1:0]   e_start, e_coin;
   int             sel [4][4] = '{'{0,1,2,3}, '{3,2,0,1}, '{2,3,1,0}, '{1,0,3,2}};
   logic [8:0]     codes [14] = '{9'h174, 9'h16B, 9'h172, 9'h175, 9'h029, 9'h014, 9'h011,
                                  9'h016, 9'h02E, 9'h034, 9'h01C, 9'h01E, 9'h036, 9'h01A};

   function automatic logic [8:0] default_map(input int e);
      case (e)
         0: return 9'h174;  1: return 9'h16B;  2: return 9'h172;  3: return 9'h175;
         4: return 9'h029;  5: return 9'h014;  6: return 9'h011;
         10: return 9'h016; 11: return 9'h02E;
         12: return 9'h034; 13: return 9'h023; 14: return 9'h02B; 15: return 9'h02D;
         16: return 9'h01C; 17: return 9'h01B;
         22: return 9'h01E; 23: return 9'h036;
         default: return 9'h000;
      endcase
   endfunction

   task automatic model_reset();
      for (int e = 0; e < NE; e++) begin
         m_map[e] = default_map(e);
         m_key[e] = 1'b0;
      end
      for (int p = 0; p < P; p++) begin
         m_pc[p] = 0; m_ps[p] = 0; m_busy[p] = 0; m_src[p] = 0; m_pass[p] = 0; m_t0[p] = 0;
      end
      m_tog = 0; m_n = 0;
      e_dir = '0; e_btn = '0; e_start = '0; e_coin = '0;
   endtask

   task automatic model_step();
      logic [F-1:0] raw [P];
      logic [F-1:0] all_or;
      logic         rc, rs, ev;
      all_or = '0;
      for (int p = 0; p < P; p++) begin
         for (int f = 0; f < F; f++) raw[p][f] = m_key[p*F+f] | joy_in[p*16+f];
         all_or = all_or | raw[p];
      end
      for (int p = 0; p < P; p++) begin
         if (joy_share) raw[p] = all_or;
         for (int g = 0; g < 4; g++) e_dir[p*4+g] = raw[p][sel[rot][g]];
         for (int b = 0; b < B; b++) e_btn[p*B+b] = raw[p][4+b];
         rs = raw[p][B+4];
         rc = raw[p][B+5];
         if (m_pass[p]) begin
            if (!rs) m_pass[p] = 0;
         end else if (m_busy[p]) begin
            if (m_n - m_t0[p] >= 2*C) begin
               m_busy[p] = 0;
               if (m_src[p] && rs) m_pass[p] = 1;
            end
         end else if (rc && !m_pc[p]) begin
            m_busy[p] = 1; m_t0[p] = m_n; m_src[p] = 0;
         end else if (AC != 0 && rs && !m_ps[p]) begin
            m_busy[p] = 1; m_t0[p] = m_n; m_src[p] = 1;
         end
         e_coin[p]  = m_busy[p] && (m_n - m_t0[p] < C);
         e_start[p] = m_pass[p] ? rs : ((!m_busy[p] && AC == 0) ? rs : 1'b0);
         m_pc[p] = rc;
         m_ps[p] = rs;
      end
      ev = ps2_key[10] != m_tog;
      for (int e = 0; e < NE; e++) begin
         if (map_wr && int'(map_idx) == e) begin
            m_map[e] = map_code;
            m_key[e] = 1'b0;
         end else if (ev && m_map[e] != 9'h000 && m_map[e] == ps2_key[8:0]) begin
            m_key[e] = ps2_key[9];
         end
      end
      m_tog = ps2_key[10];
      m_n++;
   endtask

   always @(posedge clk_sys or posedge reset) begin
      if (reset) model_reset();
      else       model_step();
   end

   // Every wait goes through here, so the model comparison runs on every cycle.
   task automatic cycle();
      @(negedge clk_sys);
      n_tests++;
      if (dir_out !== e_dir || btn_out !== e_btn || start_out !== e_start || coin_out !== e_coin) begin
         n_fail++;
         $display("FAIL model t=%0t dir %h exp %h btn %h exp %h start %b exp %b coin %b exp %b",
                  $time, dir_out, e_dir, btn_out, e_btn, start_out, e_start, coin_out, e_coin);
      end
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic key(input logic [8:0] code, input logic pressed);
      ps2_key = {~ps2_key[10], pressed, code};
   endtask

   int hi;

   initial begin
      ps2_key = '0; joy_in = '0; joy_share = 0; rot = 0;
      map_wr = 0; map_idx = 0; map_code = 0;
      repeat (3) cycle();
      chk("reset_dir", 32'(dir_out), 0);
      chk("reset_btn", 32'(btn_out), 0);
      chk("reset_coin_start", 32'({coin_out, start_out}), 0);
      reset = 0;
      cycle();

      key(9'h174, 1); cycle();
      chk("key_lat1", 32'(dir_out), 0);
      cycle();
      chk("key_right", 32'(dir_out), 32'h01);
      key(9'h174, 0); cycle(); cycle();
      chk("key_release", 32'(dir_out), 0);
      $display("[TB] keyboard direction scenario done");

      joy_in[2] = 1; rot = 1; cycle();
      chk("rot1_down", 32'(dir_out), 32'h02);
      rot = 0; cycle();
      chk("rot0_down", 32'(dir_out), 32'h04);
      rot = 2; cycle();
      chk("rot2_down", 32'(dir_out), 32'h01);
      rot = 3; cycle();
      chk("rot3_down", 32'(dir_out), 32'h08);
      joy_in = '0; rot = 0; cycle();
      $display("[TB] orientation scenario done");

      joy_in[B+4] = 1;
      for (int i = 1; i <= 9; i++) begin
         cycle();
         chk($sformatf("auto_coin_%0d", i), 32'({start_out[0], coin_out[0]}),
             32'({i == 9, i <= 4}));
      end
      joy_in[B+4] = 0; cycle();
      chk("auto_start_rel", 32'(start_out), 0);
      repeat (2) cycle();
      $display("[TB] auto-coin scenario done");

      map_wr = 1; map_idx = 4; map_code = 9'h01A; cycle();
      map_wr = 0;
      key(9'h029, 1); cycle(); cycle();
      chk("remap_space", 32'(btn_out), 0);
      key(9'h029, 0); cycle();
      key(9'h01A, 1); cycle(); cycle();
      chk("remap_z", 32'(btn_out), 32'h001);
      map_wr = 1; map_idx = 4; map_code = 9'h01A; cycle();
      map_wr = 0; cycle();
      chk("remap_clear", 32'(btn_out), 0);
      key(9'h01A, 0); cycle(); cycle();
      $display("[TB] keymap write scenario done");

      joy_in[B+5] = 1; cycle(); cycle();
      chk("coin_before_rst", 32'(coin_out), 32'h1);
      reset = 1; #1;
      chk("coin_async_rst", 32'(coin_out), 0);
      cycle();
      reset = 0;
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         hi += int'(coin_out[0]);
      end
      chk("coin_fresh_width", 32'(hi), 4);
      joy_in = '0; repeat (6) cycle();
      $display("[TB] reset mid-coin scenario done");

      joy_share = 1; joy_in[16+4] = 1; cycle();
      chk("share_on", 32'(btn_out), 32'h041);
      joy_share = 0; cycle();
      chk("share_off", 32'(btn_out), 32'h040);
      joy_in = '0; cycle();
      $display("[TB] joystick share scenario done");

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            int b;
            b = $urandom_range(0, F-1) + 16 * $urandom_range(0, P-1);
            joy_in[b] = ~joy_in[b];
         end
         if ($urandom_range(0, 5) == 0) key(codes[$urandom_range(0, 13)], 1'($urandom_range(0, 1)));
         map_wr = ($urandom_range(0, 39) == 0);
         map_idx = 8'($urandom_range(0, 30));
         map_code = ($urandom_range(0, 4) == 0) ? 9'h000 : codes[$urandom_range(0, 13)];
         if ($urandom_range(0, 49) == 0) rot = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 79) == 0) joy_share = ~joy_share;
         if ($urandom_range(0, 499) == 0) begin
            reset = 1; cycle(); reset = 0;
         end
         cycle();
      end
      map_wr = 0;
      $display("[TB] random phase done");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
